// File: rtl/rv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU FSM state
// encoding and small decode helpers used by the LSU and its lane aligner.
package rv_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_WAIT,
    S_RESP
  } lsu_state_e;

  // Access size in bytes (1, 2 or 4) from the low funct3 bits.
  function automatic logic [2:0] access_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Unsigned widths exist only for loads; 011/110/111 are never legal.
  function automatic logic funct3_legal(input logic we, input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment: store byte-mask/data placement over a
// two-word window and load byte extraction with sign/zero extension.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] beat0,
  input  logic [31:0] beat1,
  output logic [7:0]  wmask,
  output logic [63:0] wdata_lanes,
  output logic [31:0] rdata
);

  logic [3:0]  size_mask;
  logic [31:0] wdata_sized;
  logic [63:0] shifted;

  // NOTE: every output of a combinational block gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    size_mask   = 4'b1111;
    wdata_sized = wdata;
    case (funct3[1:0])
      2'b00: begin
        size_mask   = 4'b0001;
        wdata_sized = {24'd0, wdata[7:0]};
      end
      2'b01: begin
        size_mask   = 4'b0011;
        wdata_sized = {16'd0, wdata[15:0]};
      end
      default: ;
    endcase
  end

  assign wmask       = {4'd0, size_mask} << offset;
  assign wdata_lanes = {32'd0, wdata_sized} << {offset, 3'b000};
  assign shifted     = {beat1, beat0} >> {offset, 3'b000};

  always_comb begin
    rdata = shifted[31:0];
    case (funct3)
      F3_B:    rdata = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    rdata = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   rdata = {24'd0, shifted[7:0]};
      F3_HU:   rdata = {16'd0, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one request at a time, in-word accesses take one
// memory beat, word-crossing accesses are split into two aligned beats.
module load_store_unit
  import rv_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_rstrb_o,
  input  logic [31:0] mem_rdata_i,
  output logic [3:0]  mem_wmask_o,
  output logic [31:0] mem_wdata_o
);

  lsu_state_e  state_q, state_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] beat0_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [2:0]  req_size;
  logic        req_misaligned;
  logic        req_illegal;
  logic        split;
  logic [31:0] word_addr;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;
  logic [31:0] load_data;

  assign req_size       = access_bytes(req_funct3_i);
  assign req_misaligned = ((req_size == 3'd2) && req_addr_i[0]) ||
                          ((req_size == 3'd4) && (req_addr_i[1:0] != 2'b00));
  assign req_illegal    = !funct3_legal(req_we_i, req_funct3_i) ||
                          (req_misaligned && !ALLOW_MISALIGNED);

  assign split     = ({1'b0, addr_q[1:0]} + access_bytes(funct3_q)) > 3'd4;
  assign word_addr = {addr_q[31:2], 2'b00};

  // Beat 0 of a split load was parked in beat0_q during ACC1; an in-word load
  // still has its only beat on the memory bus while in WAIT.
  lsu_align u_align (
    .funct3      (funct3_q),
    .offset      (addr_q[1:0]),
    .wdata       (wdata_q),
    .beat0       (split ? beat0_q : mem_rdata_i),
    .beat1       (mem_rdata_i),
    .wmask       (lane_mask),
    .wdata_lanes (lane_data),
    .rdata       (load_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (req_valid_i) state_d = req_illegal ? S_RESP : S_ACC0;
      S_ACC0: state_d = split ? S_ACC1 : (we_q ? S_RESP : S_WAIT);
      S_ACC1: state_d = we_q ? S_RESP : S_WAIT;
      S_WAIT: state_d = S_RESP;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory strobes depend only on state, so an async reset silences them at once.
  always_comb begin
    mem_addr_o  = '0;
    mem_rstrb_o = 1'b0;
    mem_wmask_o = '0;
    mem_wdata_o = '0;
    case (state_q)
      S_ACC0: begin
        mem_addr_o  = word_addr;
        mem_rstrb_o = !we_q;
        if (we_q) begin
          mem_wmask_o = lane_mask[3:0];
          mem_wdata_o = lane_data[31:0];
        end
      end
      S_ACC1: begin
        mem_addr_o  = word_addr + 32'd4;
        mem_rstrb_o = !we_q;
        if (we_q) begin
          mem_wmask_o = lane_mask[7:4];
          mem_wdata_o = lane_data[63:32];
        end
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      beat0_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid_i) begin
        we_q     <= req_we_i;
        funct3_q <= req_funct3_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
      if (state_q == S_ACC1 && !we_q) beat0_q <= mem_rdata_i;
      if (state_d == S_RESP && state_q != S_RESP) begin
        rsp_rdata_q <= (state_q == S_WAIT) ? load_data : '0;
        rsp_err_q   <= (state_q == S_IDLE);
      end
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 1-cycle byte-masked memory,
// plus a second instance with misaligned accesses disabled.
module tb_load_store_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;

  logic        s_req_valid, s_req_ready, s_req_we;
  logic [2:0]  s_req_funct3;
  logic [31:0] s_req_addr, s_req_wdata;
  logic        s_rsp_valid, s_rsp_err;
  logic [31:0] s_rsp_rdata;
  logic [31:0] s_mem_addr, s_mem_wdata;
  logic [31:0] s_mem_rdata;
  logic        s_mem_rstrb;
  logic [3:0]  s_mem_wmask;

  assign s_mem_rdata = 32'h0BADF00D;

  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .mem_addr_o(mem_addr), .mem_rstrb_o(mem_rstrb), .mem_rdata_i(mem_rdata),
    .mem_wmask_o(mem_wmask), .mem_wdata_o(mem_wdata)
  );

  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(s_req_valid), .req_ready_o(s_req_ready), .req_we_i(s_req_we),
    .req_funct3_i(s_req_funct3), .req_addr_i(s_req_addr), .req_wdata_i(s_req_wdata),
    .rsp_valid_o(s_rsp_valid), .rsp_rdata_o(s_rsp_rdata), .rsp_err_o(s_rsp_err),
    .mem_addr_o(s_mem_addr), .mem_rstrb_o(s_mem_rstrb), .mem_rdata_i(s_mem_rdata),
    .mem_wmask_o(s_mem_wmask), .mem_wdata_o(s_mem_wdata)
  );

  // Byte-masked memory, 16 words, read data one cycle after the strobe.
  logic [31:0] mem [16];
  always @(posedge clk) begin
    if (mem_rstrb) mem_rdata <= mem[mem_addr[5:2]];
    for (int b = 0; b < 4; b++)
      if (mem_wmask[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Bus activity logs, sampled mid-cycle.
  int          wr_cnt = 0, rd_cnt = 0, s_acc_cnt = 0;
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [3:0]  wr_mask [64];
  logic [31:0] rd_addr [64];
  logic [31:0] s_last_addr = '0;
  always @(negedge clk) begin
    if (mem_wmask != 4'd0 && wr_cnt < 64) begin
      wr_addr[wr_cnt] <= mem_addr;
      wr_data[wr_cnt] <= mem_wdata;
      wr_mask[wr_cnt] <= mem_wmask;
      wr_cnt          <= wr_cnt + 1;
    end
    if (mem_rstrb && rd_cnt < 64) begin
      rd_addr[rd_cnt] <= mem_addr;
      rd_cnt          <= rd_cnt + 1;
    end
    if (s_mem_rstrb || s_mem_wmask != 4'd0 || s_mem_wdata != 32'd0) s_acc_cnt <= s_acc_cnt + 1;
    if (s_mem_rstrb) s_last_addr <= s_mem_addr;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request, scramble the request bus after acceptance and wait
  // (bounded) for the response; cyc counts cycles from accept to rsp_valid.
  task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int cyc, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    if (!sel) begin
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    end else begin
      s_req_valid = 1'b1; s_req_we = we; s_req_funct3 = f3; s_req_addr = addr; s_req_wdata = wdata;
    end
    @(negedge clk);
    req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
    req_addr = $urandom(); req_wdata = $urandom();
    s_req_valid = 1'b0; s_req_we = ~we; s_req_funct3 = 3'b111;
    s_req_addr = $urandom(); s_req_wdata = $urandom();
    cyc = 1;
    while (!(sel ? s_rsp_valid : rsp_valid) && cyc < 12) begin
      @(negedge clk);
      cyc++;
    end
    rdata = sel ? s_rsp_rdata : rsp_rdata;
    err   = sel ? s_rsp_err : rsp_err;
  endtask

  initial begin
    int          cyc, base, hits;
    logic [31:0] rd;
    logic        er;

    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    s_req_valid = 1'b0; s_req_we = 1'b0; s_req_funct3 = '0; s_req_addr = '0; s_req_wdata = '0;

    #12;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rstrb", mem_rstrb, 0);
    check("rst_wmask", mem_wmask, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", req_ready, 1);
    check("rst_s_ready", s_req_ready, 1);

    // Aligned word store then load.
    base = wr_cnt;
    issue(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, cyc, rd, er);
    check("sw_cycles", cyc, 2);
    check("sw_err", er, 0);
    check("sw_rdata", rd, 0);
    check("sw_beats", wr_cnt - base, 1);
    check("sw_addr", wr_addr[base], 32'h10);
    check("sw_mask", wr_mask[base], 4'b1111);
    check("sw_data", wr_data[base], 32'hDEADBEEF);

    base = rd_cnt;
    issue(0, 1'b0, 3'b010, 32'h10, 32'h0, cyc, rd, er);
    check("lw_cycles", cyc, 3);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_rd_addr", rd_addr[base], 32'h10);
    check("lw_rd_beats", rd_cnt - base, 1);

    // Byte store into lane 3, signed and unsigned reloads.
    base = wr_cnt;
    issue(0, 1'b1, 3'b000, 32'h13, 32'h000000A5, cyc, rd, er);
    check("sb_mask", wr_mask[base], 4'b1000);
    check("sb_data", wr_data[base], 32'hA5000000);
    check("sb_addr", wr_addr[base], 32'h10);
    issue(0, 1'b0, 3'b000, 32'h13, 32'h0, cyc, rd, er);
    check("lb_rdata", rd, 32'hFFFFFFA5);
    issue(0, 1'b0, 3'b100, 32'h13, 32'h0, cyc, rd, er);
    check("lbu_rdata", rd, 32'h000000A5);
    repeat (3) @(negedge clk);
    check("hold_rdata", rsp_rdata, 32'h000000A5);
    check("hold_valid", rsp_valid, 0);

    // Word store crossing a word boundary.
    base = wr_cnt;
    issue(0, 1'b1, 3'b010, 32'h0E, 32'h11223344, cyc, rd, er);
    check("ssw_cycles", cyc, 3);
    check("ssw_beats", wr_cnt - base, 2);
    check("ssw_addr0", wr_addr[base], 32'h0C);
    check("ssw_mask0", wr_mask[base], 4'b1100);
    check("ssw_data0", wr_data[base], 32'h33440000);
    check("ssw_addr1", wr_addr[base+1], 32'h10);
    check("ssw_mask1", wr_mask[base+1], 4'b0011);
    check("ssw_data1", wr_data[base+1], 32'h00001122);

    issue(0, 1'b0, 3'b010, 32'h0E, 32'h0, cyc, rd, er);
    check("slw_cycles", cyc, 4);
    check("slw_rdata", rd, 32'h11223344);
    issue(0, 1'b0, 3'b001, 32'h0F, 32'h0, cyc, rd, er);
    check("slh_cycles", cyc, 4);
    check("slh_rdata", rd, 32'h00002233);

    // Word 0x10 now holds A5AD1122: halfword sign/zero extension, in-word misaligned.
    issue(0, 1'b0, 3'b001, 32'h12, 32'h0, cyc, rd, er);
    check("lh_cycles", cyc, 3);
    check("lh_rdata", rd, 32'hFFFFA5AD);
    issue(0, 1'b0, 3'b101, 32'h12, 32'h0, cyc, rd, er);
    check("lhu_rdata", rd, 32'h0000A5AD);
    issue(0, 1'b0, 3'b001, 32'h11, 32'h0, cyc, rd, er);
    check("mlh_cycles", cyc, 3);
    check("mlh_rdata", rd, 32'hFFFFAD11);
    issue(0, 1'b0, 3'b000, 32'h11, 32'h0, cyc, rd, er);
    check("lb11_rdata", rd, 32'h00000011);

    // Split load at the top of the address space wraps to 0.
    base = rd_cnt;
    issue(0, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, cyc, rd, er);
    check("wrap_cycles", cyc, 4);
    check("wrap_addr0", rd_addr[base], 32'hFFFFFFFC);
    check("wrap_addr1", rd_addr[base+1], 32'h00000000);

    // Store with an unsigned width code is illegal.
    base = wr_cnt;
    issue(0, 1'b1, 3'b100, 32'h10, 32'h12345678, cyc, rd, er);
    check("ill_cycles", cyc, 1);
    check("ill_err", er, 1);
    check("ill_rdata", rd, 0);
    check("ill_no_write", wr_cnt - base, 0);

    // Misaligned rejection and reserved funct3 on the strict instance.
    issue(1, 1'b0, 3'b010, 32'h02, 32'h0, cyc, rd, er);
    check("s_mis_cycles", cyc, 1);
    check("s_mis_err", er, 1);
    check("s_mis_rdata", rd, 0);
    issue(1, 1'b0, 3'b011, 32'h00, 32'h0, cyc, rd, er);
    check("s_f3_err", er, 1);
    check("s_no_access", s_acc_cnt, 0);
    issue(1, 1'b0, 3'b010, 32'h04, 32'h0, cyc, rd, er);
    check("s_lw_cycles", cyc, 3);
    check("s_lw_err", er, 0);
    check("s_lw_rdata", rd, 32'h0BADF00D);
    check("s_lw_addr", s_last_addr, 32'h04);

    // Reset during beat 0 of a split store.
    base = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h0E; req_wdata = 32'h55667788;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rst_acc0_mask", mem_wmask, 4'b1100);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_mask", mem_wmask, 0);
    check("rst_async_addr", mem_addr, 0);
    check("rst_async_wdata", mem_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", req_ready, 1);
    repeat (4) @(negedge clk);
    hits = 0;
    for (int i = base; i < wr_cnt; i++)
      if (wr_addr[i] == 32'h10) hits++;
    check("rst_no_beat1", hits, 0);
    check("rst_word10", mem[4], 32'hA5AD1122);
    check("rst_idle_valid", rsp_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ALLOW_MISALIGNED, default 1, meaning 1 = misaligned accesses executed (split across two words when crossing), 0 = misaligned accesses rejected with error.
REQ-002 SHALL use one clock; reset is asynchronous and active-low: clk  input  1  rising-edge clock; rst_n  input  1  async active-low reset.
REQ-003 SHALL have req_valid_i  input  1  core request valid.
REQ-004 SHALL have req_ready_o  output  1  request accepted when valid&ready at clk edge.
REQ-005 SHALL have req_we_i  input  1  1 = store, 0 = load.
REQ-006 SHALL have req_funct3_i  input  3  RV32I width code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-007 SHALL have req_addr_i  input  32  byte address; req_wdata_i  input  32  store data, LSB-justified.
REQ-008 SHALL have rsp_valid_o  output  1  one-cycle completion pulse; rsp_rdata_o  output  32  extended load data (0 for stores/errors); rsp_err_o  output  1  access rejected, valid with rsp_valid_o.
REQ-009 SHALL have memory-side ports: mem_addr_o  output  32  word-aligned address; mem_rstrb_o  output  1  read strobe; mem_rdata_i  input  32  read data, valid the cycle after strobe; mem_wmask_o  output  4  byte write enables; mem_wdata_o  output  32  lane-aligned write data.

Function
REQ-010 SHALL implement FSM states IDLE, ACC0, ACC1, WAIT, RESP; req_ready_o=1 only in IDLE.
REQ-011 SHALL decode size n=1/2/4 and offset o=addr[1:0]; split when o+n>4; misaligned when addr not a multiple of n.
REQ-012 SHALL on acceptance of an illegal request (funct3 011/110/111, store with 100/101, or misaligned with ALLOW_MISALIGNED=0) go IDLE->RESP, issue no memory access, rsp_err_o=1.
REQ-013 SHALL in ACC0 drive mem_addr_o={addr[31:2],2'b00}; in ACC1 drive that address +4 (modulo 2^32 wrap).
REQ-014 SHALL for stores drive mem_wmask_o = bits[3:0] (ACC0) / [7:4] (ACC1) of (n-byte mask << o) and mem_wdata_o = low/high word of (wdata << 8*o) in 64 bits.
REQ-015 SHALL for loads assert mem_rstrb_o in ACC0/ACC1, capture beat-0 data in the cycle after ACC0 and beat-1 data in WAIT.
REQ-016 SHALL form load result as ({beat1,beat0} >> 8*o) truncated to n bytes, sign-extended for LB/LH, zero-extended for LBU/LHU/LW.
REQ-017 SHALL sequence: aligned/in-word store ACC0->RESP; split store ACC0->ACC1->RESP; in-word load ACC0->WAIT->RESP; split load ACC0->ACC1->WAIT->RESP; RESP->IDLE.
REQ-018 SHALL hold mem_rstrb_o=0 and mem_wmask_o=0 in every state other than the active ACC beat.
REQ-019 SHALL register rsp_rdata_o/rsp_err_o, holding them until next RESP; rsp_valid_o high exactly in RESP.
REQ-020 SHALL ignore req_* changes after acceptance (request fields latched at accept edge).

Reset
REQ-021 SHALL on rst_n low immediately force state IDLE, req_ready_o=1 after release, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, mem_rstrb_o=0, mem_wmask_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-022 SHALL on reset mid-transaction drop the transaction; a split store's beat 1 SHALL never issue (beat-0 partial write remains, by design).

Structure
REQ-023 SHALL take funct3 width codes and FSM state encoding from shared package rv_pkg.
REQ-024 SHALL place combinational lane alignment (mask/data shift, load extract/extend) in sub-module lsu_align.

Verification (against 1-cycle-latency byte-masked memory)
REQ-025 SW 0x10 data 0xDEADBEEF -> one cycle addr 0x10 wmask 1111 wdata 0xDEADBEEF, rsp_valid 2 cycles after accept; LW 0x10 -> 0xDEADBEEF, rsp_valid 3 cycles after accept.
REQ-026 SB 0x13 data 0x000000A5 -> wmask 1000 wdata 0xA5000000; LB 0x13 -> 0xFFFFFFA5; LBU 0x13 -> 0x000000A5.
REQ-027 SW 0x0E data 0x11223344 -> beat0 addr 0x0C wmask 1100 wdata 0x33440000, beat1 addr 0x10 wmask 0011 wdata 0x00001122; LW 0x0E -> 0x11223344 (4 cycles); LH 0x0F -> 0x00002233.
REQ-028 ALLOW_MISALIGNED=0, LW 0x02 -> rsp_err_o=1, rsp_rdata_o=0, mem_rstrb_o/mem_wmask_o never asserted; funct3 011 -> same error.
REQ-029 rst_n low during ACC0 of split store SW 0x0E -> mem_wmask_o drops to 0 asynchronously, addr 0x10 never written, req_ready_o=1 first cycle after release.
